// File: rtl/alu_op_sequencer_if.sv
// Opcode handshake and status bundle between the upstream controller and alu_op_sequencer.
interface alu_op_sequencer_if;
    logic       in_valid;
    logic [3:0] in_op;
    logic       in_ready;
    logic [3:0] op_sel;
    logic       op_valid;
    logic       done;
    logic       busy;
    logic [7:0] retired_cnt;

    modport master (
        output in_valid, in_op,
        input  in_ready, op_sel, op_valid, done, busy, retired_cnt
    );

    modport slave (
        input  in_valid, in_op,
        output in_ready, op_sel, op_valid, done, busy, retired_cnt
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Opcode FIFO plus issue FSM feeding the ALU op-select decoder; storage ops 0xD-0xF span MEM_LAT cycles.
// Optional macro ALU_SEQ_LOAD_BUBBLE_EN inserts one idle cycle after every LOAD (0xF).
module alu_op_sequencer #(
    parameter int DEPTH   = 4,
    parameter int MEM_LAT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    alu_op_sequencer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MEM_LAT) + 1;
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(MEM_LAT - 2);

`ifdef ALU_SEQ_LOAD_BUBBLE_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_WAIT = 2'd2, ST_BUBBLE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_WAIT = 2'd2} state_t;
`endif

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= 4'hD);
    endfunction

    logic [3:0]    mem_r [DEPTH];
    logic [AW:0]   wr_ptr_r, rd_ptr_r;
    state_t        state_r, state_s;
    logic [3:0]    op_sel_r, op_sel_s;
    logic          op_valid_r, op_valid_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [7:0]    retired_r;
    logic          full_s, empty_s, push_s, pop_s, done_s, advance_s, in_ready_s;
    logic [3:0]    head_s;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign in_ready_s = !full_s && !flush;
    assign push_s     = bus.in_valid && in_ready_s;
    assign head_s     = mem_r[rd_ptr_r[AW-1:0]];

    assign bus.in_ready    = in_ready_s;
    assign bus.op_sel      = op_sel_r;
    assign bus.op_valid    = op_valid_r;
    assign bus.done        = done_s;
    assign bus.busy        = (state_r != ST_IDLE) || !empty_s;
    assign bus.retired_cnt = retired_r;

    // Opcode storage; entries are only read after being written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= bus.in_op;
        end else begin
            mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
        end
    end

    // FIFO read/write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // FSM state, registered ALU selection, wait counter and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            op_sel_r   <= 4'h0;
            op_valid_r <= 1'b0;
            cnt_r      <= CNT_ZERO;
            retired_r  <= 8'd0;
        end else begin
            state_r    <= state_s;
            op_sel_r   <= op_sel_s;
            op_valid_r <= op_valid_s;
            cnt_r      <= cnt_s;
            retired_r  <= done_s ? (retired_r + 8'd1) : retired_r;
        end
    end

    // Next-state, issue and completion decode; flush overrides all of it.
    always_comb begin
        state_s    = state_r;
        op_sel_s   = op_sel_r;
        op_valid_s = op_valid_r;
        cnt_s      = cnt_r;
        pop_s      = 1'b0;
        done_s     = 1'b0;
        advance_s  = 1'b0;
        if (flush) begin
            state_s    = ST_IDLE;
            op_sel_s   = 4'h0;
            op_valid_s = 1'b0;
            cnt_s      = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: advance_s = 1'b1;
`ifdef ALU_SEQ_LOAD_BUBBLE_EN
                ST_BUBBLE: advance_s = 1'b1;
`endif
                ST_EXEC: begin
                    if (is_mem_op(op_sel_r)) begin
                        cnt_s   = WAIT_LOAD;
                        state_s = ST_WAIT;
                    end else begin
                        done_s    = 1'b1;
                        advance_s = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == CNT_ZERO) begin
                        done_s    = 1'b1;
                        advance_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_s    = ST_IDLE;
                    op_valid_s = 1'b0;
                end
            endcase

            // A completing op or an idle slot hands over to the next queued opcode.
`ifdef ALU_SEQ_LOAD_BUBBLE_EN
            if (done_s && (op_sel_r == 4'hF)) begin
                op_valid_s = 1'b0;
                state_s    = ST_BUBBLE;
            end else
`endif
            if (advance_s && !empty_s) begin
                pop_s      = 1'b1;
                op_sel_s   = head_s;
                op_valid_s = 1'b1;
                state_s    = ST_EXEC;
            end else if (advance_s) begin
                op_valid_s = 1'b0;
                state_s    = ST_IDLE;
            end else begin
                pop_s = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: scoreboard of issued opcodes plus cycle-accurate status checks.
module tb_alu_op_sequencer;
    logic clk;
    logic rst_n;
    logic flush;
    int   checks;
    int   failures;
    logic [3:0] sb_q[$];
    logic [7:0] model_cnt;
    int   waits;

    alu_op_sequencer_if bus();

    alu_op_sequencer #(.DEPTH(4), .MEM_LAT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle sample: every done pops the oldest expected opcode.
    task automatic sb_sample();
        logic [3:0] exp_op;
        @(negedge clk);
        if (rst_n && bus.done) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_op = sb_q.pop_front();
                chk("sb_op_sel", bus.op_sel, exp_op);
                chk("sb_op_valid", bus.op_valid, 1'b1);
                chk("sb_retired", bus.retired_cnt, model_cnt);
                model_cnt = model_cnt + 8'd1;
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [3:0] op, output int nwait);
        bit acc;
        acc = 1'b0;
        nwait = 0;
        bus.in_valid = 1'b1;
        bus.in_op = op;
        for (int k = 0; k < 64; k++) begin
            sb_sample();
            if (bus.in_ready) begin
                acc = 1'b1;
                break;
            end
            nwait++;
            adv();
        end
        if (!acc) begin
            chk("push_timeout", 32'd0, 32'd1);
        end else begin
            adv();
            sb_q.push_back(op);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 64; k++) begin
            sb_sample();
            if (!bus.busy) begin
                idle = 1'b1;
                break;
            end
            adv();
        end
        chk("drain_idle", idle, 1'b1);
        chk("drain_retired", bus.retired_cnt, model_cnt);
        chk("drain_sb_left", sb_q.size(), 0);
        adv();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model_cnt = 8'd0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op = 4'h0;

        // Reset values
        #3;
        chk("rst_op_sel", bus.op_sel, 4'h0);
        chk("rst_op_valid", bus.op_valid, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_retired", bus.retired_cnt, 8'd0);
        #17;
        rst_n = 1'b1;
        adv();
        sb_sample();
        chk("rel_in_ready", bus.in_ready, 1'b1);
        chk("rel_busy", bus.busy, 1'b0);
        adv();

        // Back-to-back single-cycle ops
        push_op(4'h0, waits);
        push_op(4'h5, waits);
        push_op(4'hB, waits);
        sb_sample();
        chk("b2b_op5", bus.op_sel, 4'h5);
        chk("b2b_done5", bus.done, 1'b1);
        adv();
        sb_sample();
        chk("b2b_opB", bus.op_sel, 4'hB);
        chk("b2b_busyB", bus.busy, 1'b1);
        adv();
        sb_sample();
        chk("b2b_busy_fall", bus.busy, 1'b0);
        chk("b2b_valid_fall", bus.op_valid, 1'b0);
        chk("b2b_retired", bus.retired_cnt, 8'd3);
        adv();

        // Storage op holds for MEM_LAT cycles
        push_op(4'hD, waits);
        push_op(4'h1, waits);
        for (int c = 0; c < 3; c++) begin
            sb_sample();
            chk("sto_op_sel", bus.op_sel, 4'hD);
            chk("sto_valid", bus.op_valid, 1'b1);
            chk("sto_done", bus.done, (c == 2) ? 1'b1 : 1'b0);
            adv();
        end
        sb_sample();
        chk("sto_next_op", bus.op_sel, 4'h1);
        chk("sto_next_done", bus.done, 1'b1);
        adv();
        sb_sample();
        chk("sto_retired", bus.retired_cnt, 8'd5);
        adv();

        // Fill the FIFO behind stalled storage ops
        push_op(4'hD, waits);
        push_op(4'hE, waits);
        push_op(4'hF, waits);
        push_op(4'h1, waits);
        push_op(4'h2, waits);
        push_op(4'h3, waits);
        chk("full_no_stall", waits, 0);
        push_op(4'h4, waits);
        chk("full_stall_cycles", waits, 2);
        drain();
        chk("full_retired", bus.retired_cnt, 8'd12);

        // Flush during LOAD wait with two queued ops
        push_op(4'hF, waits);
        push_op(4'h7, waits);
        push_op(4'h8, waits);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op = 4'h9;
        sb_sample();
        chk("flush_in_ready", bus.in_ready, 1'b0);
        chk("flush_done", bus.done, 1'b0);
        adv();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        sb_q.delete();
        sb_sample();
        chk("flush_valid", bus.op_valid, 1'b0);
        chk("flush_busy", bus.busy, 1'b0);
        chk("flush_done_after", bus.done, 1'b0);
        chk("flush_retired", bus.retired_cnt, 8'd12);
        adv();
        push_op(4'h2, waits);
        drain();
        chk("post_flush_retired", bus.retired_cnt, 8'd13);

        // LOAD followed by a dependent op
        push_op(4'hF, waits);
        push_op(4'h3, waits);
        sb_sample();
        adv();
        sb_sample();
        adv();
        sb_sample();
        chk("load_done", bus.done, 1'b1);
        chk("load_sel", bus.op_sel, 4'hF);
        adv();
`ifdef ALU_SEQ_LOAD_BUBBLE_EN
        sb_sample();
        chk("bubble_valid", bus.op_valid, 1'b0);
        chk("bubble_done", bus.done, 1'b0);
        chk("bubble_busy", bus.busy, 1'b1);
        adv();
`endif
        sb_sample();
        chk("after_load_op", bus.op_sel, 4'h3);
        chk("after_load_valid", bus.op_valid, 1'b1);
        adv();
        drain();
        chk("load_retired", bus.retired_cnt, 8'd15);

        // Asynchronous reset in the middle of a storage wait
        push_op(4'hD, waits);
        adv();
        adv();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.op_valid, 1'b0);
        chk("arst_op_sel", bus.op_sel, 4'h0);
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_retired", bus.retired_cnt, 8'd0);
        sb_q.delete();
        model_cnt = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        adv();

        // Retire counter wraps past 255
        for (int i = 0; i < 260; i++) begin
            push_op(4'(i % 13), waits);
        end
        drain();
        chk("wrap_retired", bus.retired_cnt, 8'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
